i2c_wr_arbiter: RTL

Round-robin arbiter and sequencer that shares one `I2C_WRITE_BYTE` engine between `NREQ` register-write requesters (fan controller, LED driver, sensor config). It latches the winning requester's slave address, pointer and data, and runs the engine's GO/END_OK handshake for exactly one 3-byte write. It returns a per-requester done pulse with ACK/timeout status. A timeout watchdog resets a hung engine.

---
 rtl/i2c_wr_pkg.sv | 21 ++
 rtl/i2c_wr_arbiter_rr_arbiter.sv | 28 ++
 rtl/i2c_wr_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_wr_pkg.sv
// Shared types and helpers for the I2C write arbiter.
package i2c_wr_pkg;
  localparam int unsigned DEF_TIMEOUT  = 4095;
  localparam int unsigned DEF_RST_HOLD = 4;
  localparam int unsigned MAX_NREQ     = 8;
  localparam int unsigned BUS_W        = 8 * MAX_NREQ;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_BUSY,
    ST_FIN,
    ST_RECOVER
  } state_e;

  // Byte idx of a flattened per-requester bus.
  function automatic logic [7:0] bus_byte(input logic [BUS_W-1:0] bus, input logic [2:0] idx);
    return bus[{idx, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/i2c_wr_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after the last-granted index.
module rr_arbiter import i2c_wr_pkg::*; #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  logic [IW-1:0] c;

  always_comb begin
    valid = 1'b0;
    gnt   = '0;
    idx   = '0;
    c     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      c = IW'((32'(last) + k) % NREQ);
      if (!valid && req[c]) begin
        valid  = 1'b1;
        gnt[c] = 1'b1;
        idx    = c;
      end
    end
  end
endmodule

// File: rtl/i2c_wr_arbiter.sv
// Shares one I2C_WRITE_BYTE engine among NREQ requesters: arbitration,
// GO/END_OK sequencing, ACK capture and watchdog recovery.
module i2c_wr_arbiter import i2c_wr_pkg::*; #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
  parameter int unsigned RST_HOLD = DEF_RST_HOLD
) (
  input  logic              PT_CK,
  input  logic              RESET,
  input  logic [NREQ-1:0]   REQ,
  input  logic [8*NREQ-1:0] REQ_SLAVE,
  input  logic [8*NREQ-1:0] REQ_POINTER,
  input  logic [8*NREQ-1:0] REQ_WDATA,
  output logic [NREQ-1:0]   GNT,
  output logic [NREQ-1:0]   DONE,
  output logic              ERR_NACK,
  output logic              ERR_TMO,
  output logic              GO,
  output logic [7:0]        SLAVE_ADDRESS,
  output logic [7:0]        POINTER,
  output logic [7:0]        WDATA8,
  output logic              ENG_RESET_N,
  input  logic              END_OK,
  input  logic              ACK_OK
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam int unsigned RW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   win_q, win_d;
  logic [NREQ-1:0] win_oh_q, win_oh_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            err_nack_q, err_nack_d;
  logic            err_tmo_q, err_tmo_d;
  logic            go_q, go_d;
  logic [7:0]      sa_q, sa_d;
  logic [7:0]      pt_q, pt_d;
  logic [7:0]      wd_q, wd_d;
  logic            eng_rst_n_q, eng_rst_n_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic [RW-1:0]   rec_q, rec_d;
  logic            ack_q, ack_d;
  logic            abort;
  logic            expired;

  logic            arb_valid;
  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (REQ),
    .last  (last_q),
    .valid (arb_valid),
    .gnt   (arb_gnt),
    .idx   (arb_idx)
  );

  assign expired = (wdog_q >= WW'(TIMEOUT - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    win_oh_d    = win_oh_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    err_nack_d  = 1'b0;
    err_tmo_d   = 1'b0;
    go_d        = 1'b1;
    sa_d        = sa_q;
    pt_d        = pt_q;
    wd_d        = wd_q;
    wdog_d      = wdog_q;
    rec_d       = rec_q;
    ack_d       = ack_q;
    abort       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          win_d    = arb_idx;
          win_oh_d = arb_gnt;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        gnt_d   = win_oh_q;
        sa_d    = bus_byte(BUS_W'(REQ_SLAVE), 3'(win_q));
        pt_d    = bus_byte(BUS_W'(REQ_POINTER), 3'(win_q));
        wd_d    = bus_byte(BUS_W'(REQ_WDATA), 3'(win_q));
        wdog_d  = '0;
        ack_d   = 1'b0;
        state_d = ST_START;
      end
      ST_START: begin
        wdog_d = wdog_q + 1'b1;
        // An engine that is already running counts as started.
        if (!END_OK) begin
          state_d = ST_BUSY;
        end else if (expired) begin
          abort = 1'b1;
        end else begin
          go_d = 1'b0;
        end
      end
      ST_BUSY: begin
        wdog_d = wdog_q + 1'b1;
        if (END_OK) begin
          state_d = ST_FIN;
        end else begin
          ack_d = ACK_OK;
          if (expired) abort = 1'b1;
        end
      end
      ST_FIN: begin
        done_d     = gnt_q;
        err_nack_d = ~ack_q;
        gnt_d      = '0;
        last_d     = win_q;
        state_d    = ST_IDLE;
      end
      ST_RECOVER: begin
        if (rec_q == RW'(RST_HOLD - 1)) begin
          state_d = ST_IDLE;
        end else begin
          rec_d = rec_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      done_d    = gnt_q;
      err_tmo_d = 1'b1;
      gnt_d     = '0;
      last_d    = win_q;
      rec_d     = '0;
      state_d   = ST_RECOVER;
    end

    eng_rst_n_d = (state_d != ST_RECOVER);
  end

  always_ff @(posedge PT_CK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      last_q      <= IW'(NREQ - 1);
      win_q       <= '0;
      win_oh_q    <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_nack_q  <= 1'b0;
      err_tmo_q   <= 1'b0;
      go_q        <= 1'b1;
      sa_q        <= '0;
      pt_q        <= '0;
      wd_q        <= '0;
      eng_rst_n_q <= 1'b0;
      wdog_q      <= '0;
      rec_q       <= '0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      win_oh_q    <= win_oh_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_nack_q  <= err_nack_d;
      err_tmo_q   <= err_tmo_d;
      go_q        <= go_d;
      sa_q        <= sa_d;
      pt_q        <= pt_d;
      wd_q        <= wd_d;
      eng_rst_n_q <= eng_rst_n_d;
      wdog_q      <= wdog_d;
      rec_q       <= rec_d;
      ack_q       <= ack_d;
    end
  end

  assign GNT           = gnt_q;
  assign DONE          = done_q;
  assign ERR_NACK      = err_nack_q;
  assign ERR_TMO       = err_tmo_q;
  assign GO            = go_q;
  assign SLAVE_ADDRESS = sa_q;
  assign POINTER       = pt_q;
  assign WDATA8        = wd_q;
  assign ENG_RESET_N   = eng_rst_n_q;
endmodule
